// File: rtl/burst_mem_pkg.sv
// -----------------------------------------------------------------------------
// burst_mem_pkg
// Shared types and constants for the burst memory responder.
//   state_t     : responder FSM states
//   BEATS       : beats per line burst
//   BEAT_W      : width of one beat
//   LINE_W      : width of one cache line
//   LINE_OFFSET : low address bits covered by one line (byte offset in a line)
//   lfsr_next   : one step of the x^8+x^6+x^5+x^4+1 jitter LFSR
// -----------------------------------------------------------------------------
package burst_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        DONE
    } state_t;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = BEATS * BEAT_W;
    localparam int LINE_OFFSET = 5;

    // Fibonacci form, shifting left; taps 8,6,5,4 map to bits 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/burst_mem_array.sv
// -----------------------------------------------------------------------------
// burst_mem_array
// Beat-wide storage behind the responder: DEPTH_WORDS x BEAT_W, one synchronous
// write port and one synchronous (registered) read port.
// Ports:
//   clk      : clock
//   reset    : asynchronous active-high reset, clears only the read register
//   wr_en    : write strobe
//   wr_addr  : write word address ({line index, beat})
//   wr_data  : write data
//   rd_en    : read strobe, loads rd_data on the edge
//   rd_addr  : read word address ({line index, beat})
//   rd_data  : registered read data
// Memory contents are never reset.
// -----------------------------------------------------------------------------
module burst_mem_array
    import burst_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BEAT_W-1:0] rd_data
);

    logic [BEAT_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register is cleared so burst_o reads 0 the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// -----------------------------------------------------------------------------
// burst_mem_responder
// Memory-side responder for 4x64-bit line bursts. Accepts a line read or write,
// waits LATENCY cycles, then streams (read) or absorbs (write) 4 beats while
// resp_o is high.
// Ports:
//   clk       : clock
//   reset     : asynchronous active-high reset
//   address_i : line address, index = address_i[5 +: IDX_W]
//   read_i    : line read request (wins over write_i)
//   write_i   : line write request
//   burst_i   : write beat data, sampled on each edge that ends a resp_o cycle
//   burst_o   : read beat data, stable during each resp_o cycle
//   resp_o    : high for exactly 4 consecutive cycles per request
// Optional macro BURST_MEM_JITTER_EN: adds 0..7 extra wait cycles taken from an
// 8-bit LFSR (seed 8'hA5) that steps once per accepted request.
// -----------------------------------------------------------------------------
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o
);

    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int ADDR_W = IDX_W + 2;
    localparam int CNT_W  = $clog2(LATENCY + 8);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        beat_reg, beat_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              op_rd_reg, op_rd_next;
    logic              resp_reg, resp_next;

    logic              accept;
    logic [2:0]        extra_wait;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [1:0]        beat_inc;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{address_i[31:LINE_OFFSET+IDX_W], address_i[LINE_OFFSET-1:0]};

    assign accept   = (state_reg == IDLE) && (read_i || write_i);
    assign beat_inc = beat_reg + 2'd1;

`ifdef BURST_MEM_JITTER_EN
    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= 8'hA5;
        end else if (accept) begin
            lfsr_reg <= lfsr_next(lfsr_reg);
        end
    end

    // The value present at acceptance sets this request's extra wait.
    assign extra_wait = lfsr_reg[2:0];
`else
    assign extra_wait = 3'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            beat_reg  <= '0;
            idx_reg   <= '0;
            op_rd_reg <= 1'b0;
            resp_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            beat_reg  <= beat_next;
            idx_reg   <= idx_next;
            op_rd_reg <= op_rd_next;
            resp_reg  <= resp_next;
        end
    end

    // Read addresses are issued one edge early so the registered array output
    // lands exactly on the beat it belongs to.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        beat_next  = beat_reg;
        idx_next   = idx_reg;
        op_rd_next = op_rd_reg;
        resp_next  = resp_reg;
        rd_en      = 1'b0;
        rd_addr    = {idx_reg, beat_reg};
        wr_en      = 1'b0;
        wr_addr    = {idx_reg, beat_reg};

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    idx_next   = address_i[LINE_OFFSET +: IDX_W];
                    op_rd_next = read_i;
                    cnt_next   = LAT_M1 + CNT_W'(extra_wait);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    beat_next  = 2'd0;
                    resp_next  = 1'b1;
                    state_next = op_rd_reg ? RBURST : WBURST;
                    if (op_rd_reg) begin
                        rd_en   = 1'b1;
                        rd_addr = {idx_reg, 2'd0};
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RBURST: begin
                if (beat_reg == 2'd3) begin
                    resp_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    beat_next = beat_inc;
                    rd_en     = 1'b1;
                    rd_addr   = {idx_reg, beat_inc};
                end
            end
            WBURST: begin
                wr_en = 1'b1;
                if (beat_reg == 2'd3) begin
                    resp_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    beat_next = beat_inc;
                end
            end
            DONE: begin
                beat_next  = 2'd0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                resp_next  = 1'b0;
            end
        endcase
    end

    burst_mem_array #(
        .DEPTH_WORDS (DEPTH_LINES * BEATS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (burst_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (burst_o)
    );

    assign resp_o = resp_reg;

endmodule

// File: tb/tb_burst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_burst_mem_responder
// Directed bench for burst_mem_responder: line writes and reads, latency,
// read-over-write priority, reset mid write burst, and (with
// BURST_MEM_JITTER_EN) LFSR-driven latency.
// -----------------------------------------------------------------------------
module tb_burst_mem_responder;

    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model_lfsr;

    always #5 clk = ~clk;

    burst_mem_responder #(
        .DEPTH_LINES (256),
        .LATENCY     (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .resp_o    (resp_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected wait for the request just accepted; steps the reference LFSR.
    task automatic model_accept(output int elat);
        elat = LATENCY;
`ifdef BURST_MEM_JITTER_EN
        elat = LATENCY + int'(model_lfsr[2:0]);
        model_lfsr = {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
`endif
    endtask

    // Counts edges after the accepting edge until resp_o rises (bounded).
    task automatic wait_resp(input string tag);
        int lat;
        int elat;
        model_accept(elat);
        lat = 0;
        while (!resp_o && lat < 40) begin
            step();
            lat++;
        end
        chk($sformatf("%s latency", tag), 64'(lat), 64'(elat));
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic both,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] exp_beat [4];
        exp_beat[0] = d0; exp_beat[1] = d1; exp_beat[2] = d2; exp_beat[3] = d3;
        address_i = addr;
        read_i    = 1'b1;
        write_i   = both;
        burst_i   = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        wait_resp(tag);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk($sformatf("%s resp beat%0d", tag, k), 64'(resp_o), 64'd1);
            chk($sformatf("%s data beat%0d", tag, k), burst_o, exp_beat[k]);
        end
        step();
        chk($sformatf("%s resp end", tag), 64'(resp_o), 64'd0);
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        $display("read  %s addr=%h beats=%h %h %h %h", tag, addr, d0, d1, d2, d3);
    endtask

    // abort_beat < 4 raises reset during that beat instead of finishing.
    task automatic do_write(input string tag, input logic [31:0] addr, input int abort_beat,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] beat_data [4];
        beat_data[0] = d0; beat_data[1] = d1; beat_data[2] = d2; beat_data[3] = d3;
        address_i = addr;
        write_i   = 1'b1;
        read_i    = 1'b0;
        step();
        wait_resp(tag);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk($sformatf("%s resp beat%0d", tag, k), 64'(resp_o), 64'd1);
            burst_i = beat_data[k];
            if (k == abort_beat) begin
                #2 reset = 1'b1;
                #1;
                chk($sformatf("%s async resp", tag), 64'(resp_o), 64'd0);
                chk($sformatf("%s async burst_o", tag), burst_o, 64'd0);
                model_lfsr = 8'hA5;
                write_i = 1'b0;
                step();
                reset = 1'b0;
                step();
                $display("write %s addr=%h aborted in beat %0d", tag, addr, k);
                return;
            end
        end
        step();
        chk($sformatf("%s resp end", tag), 64'(resp_o), 64'd0);
        write_i = 1'b0;
        step();
        $display("write %s addr=%h beats=%h %h %h %h", tag, addr, d0, d1, d2, d3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address_i  = '0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        burst_i    = '0;
        model_lfsr = 8'hA5;
        repeat (3) step();
        chk("reset resp_o", 64'(resp_o), 64'd0);
        chk("reset burst_o", burst_o, 64'd0);
        reset = 1'b0;
        step();

        // Line 3 preload then read back.
        do_write("pre_l3", 32'h60, 4, 64'h1, 64'h2, 64'h3, 64'h4);
        do_read("rd_l3", 32'h60, 1'b0, 64'h1, 64'h2, 64'h3, 64'h4);

        // Line 4 write/read round trip.
        do_write("wr_l4", 32'h80, 4, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        do_read("rd_l4", 32'h80, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);

        // Read wins over a simultaneous write; line 1 must stay unchanged.
        do_write("wr_l1", 32'h20, 4, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
        do_read("both_l1", 32'h20, 1'b1, 64'h1111, 64'h2222, 64'h3333, 64'h4444);
        do_read("rd_l1", 32'h20, 1'b0, 64'h1111, 64'h2222, 64'h3333, 64'h4444);

        // Reset during write beat 2 of line 4: beats 0-1 new, 2-3 old.
        do_write("abort_l4", 32'h80, 2, 64'hEEEE_EEEE_EEEE_EEEE, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202);
        do_read("rd_l4_after", 32'h80, 1'b0, 64'hEEEE_EEEE_EEEE_EEEE, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);

        // Back-to-back reads; latency follows the reference LFSR when jitter is built in.
        for (int i = 0; i < 16; i++) begin
            do_read($sformatf("seq%0d", i), 32'h60, 1'b0, 64'h1, 64'h2, 64'h3, 64'h4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
